image_pixel_reader: RTL and testbench

Read-side master for the three-channel image BRAM controller. On start it scans pixel addresses from 0 to NUM_PIXELS-1. For each address it reads the red, green and blue bytes through the controller's channel mux and emits one packed 24-bit RGB pixel on a valid/ready stream toward downstream processing or display logic. It never writes; all controller write inputs are tied inactive.

---
 rtl/image_pixel_reader.sv | 159 +++++++++++++++
 tb/tb_image_pixel_reader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_pixel_reader.sv
// Read-side master: scans pixel addresses 0..NUM_PIXELS-1 and packs R/G/B bytes into 24-bit pixels.
// Latency: first pix_valid 4 cycles after the start edge, then 5 cycles per pixel with pix_ready held high.
// Backpressure: while pix_valid=1 and pix_ready=0 the pixel, pix_last and bram_addr hold and the scan pauses.
module image_pixel_reader #(
  parameter int ADDR_W     = 17,
  parameter int NUM_PIXELS = 76800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [1:0]        bram_channel,
  output logic              bram_we,
  output logic [7:0]        bram_data_in,
  input  logic [7:0]        bram_data_out,
  output logic [23:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CAP_R,
    CAP_G,
    CAP_B,
    PRESENT
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       launch;
  logic       cap_r;
  logic       cap_g;
  logic       cap_b;
  logic       handshake;
  logic       kill;
  logic [7:0] red_q;
  logic [7:0] green_q;

  // This master only reads, so the controller write port is tied off.
  assign bram_we      = 1'b0;
  assign bram_data_in = 8'h00;
  assign busy         = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, channel select and datapath strobes; abort overrides everything outside IDLE.
  always_comb begin
    state_nxt    = state;
    bram_channel = 2'b01;
    launch       = 1'b0;
    cap_r        = 1'b0;
    cap_g        = 1'b0;
    cap_b        = 1'b0;
    handshake    = 1'b0;
    kill         = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          launch    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = CAP_R;
      end
      CAP_R: begin
        cap_r     = 1'b1;
        state_nxt = CAP_G;
      end
      CAP_G: begin
        bram_channel = 2'b10;
        cap_g        = 1'b1;
        state_nxt    = CAP_B;
      end
      CAP_B: begin
        bram_channel = 2'b11;
        cap_b        = 1'b1;
        state_nxt    = PRESENT;
      end
      PRESENT: begin
        if (pix_valid && pix_ready) begin
          handshake = 1'b1;
          state_nxt = pix_last ? IDLE : SETUP;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort && (state != IDLE)) begin
      kill      = 1'b1;
      cap_r     = 1'b0;
      cap_g     = 1'b0;
      cap_b     = 1'b0;
      handshake = 1'b0;
      state_nxt = IDLE;
    end
  end

  // Address counter, byte capture and pixel output registers; address is held from SETUP through CAP_B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_addr <= '0;
      red_q     <= 8'h00;
      green_q   <= 8'h00;
      pix_data  <= 24'h000000;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        bram_addr <= '0;
        pix_valid <= 1'b0;
        pix_last  <= 1'b0;
      end else begin
        if (launch) begin
          bram_addr <= '0;
        end
        if (cap_r) begin
          red_q <= bram_data_out;
        end
        if (cap_g) begin
          green_q <= bram_data_out;
        end
        if (cap_b) begin
          pix_data  <= {red_q, green_q, bram_data_out};
          pix_valid <= 1'b1;
          pix_last  <= (bram_addr == LAST_ADDR);
        end
        if (handshake) begin
          pix_valid <= 1'b0;
          pix_last  <= 1'b0;
          if (pix_last) begin
            done <= 1'b1;
          end else begin
            bram_addr <= bram_addr + ADDR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_image_pixel_reader.sv
// Bench for image_pixel_reader with a 4-pixel frame and a behavioural synchronous-read BRAM.
// Expected pixels are queued when a scan is launched and popped as pixels appear.
// Outputs are sampled on the falling edge; inputs change right after sampling.
module tb_image_pixel_reader;

  localparam int AW = 2;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] bram_addr;
  logic [1:0]    bram_channel;
  logic          bram_we;
  logic [7:0]    bram_data_in;
  logic [7:0]    bram_data_out;
  logic [23:0]   pix_data;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic          pix_last;

  logic [7:0]  r_mem [NP];
  logic [7:0]  g_mem [NP];
  logic [7:0]  b_mem [NP];
  logic [7:0]  r_q, g_q, b_q;
  logic [23:0] exp_q [$];
  int          checks = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  image_pixel_reader #(.ADDR_W(AW), .NUM_PIXELS(NP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .bram_addr(bram_addr), .bram_channel(bram_channel), .bram_we(bram_we),
    .bram_data_in(bram_data_in), .bram_data_out(bram_data_out), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last)
  );

  // Three synchronous-read BRAMs sharing one address; the channel select muxes the outputs.
  always @(posedge clk) begin
    r_q <= r_mem[bram_addr];
    g_q <= g_mem[bram_addr];
    b_q <= b_mem[bram_addr];
  end
  assign bram_data_out = (bram_channel == 2'b10) ? g_q : (bram_channel == 2'b11) ? b_q :
                         (bram_channel == 2'b01) ? r_q : 8'hEE;

  function automatic logic [23:0] px(input int a);
    logic [7:0] r;
    r = 8'(a);
    return {r, r + 8'h40, r + 8'h80};
  endfunction

  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(px(i));
  endtask

  task automatic start_scan;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({busy, done, pix_valid, pix_last, bram_channel, bram_addr, pix_data} !== {4'b0000, 2'b01, 2'b00, 24'h0}) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b vld=%b last=%b ch=%b addr=%0d dat=%h, expected 0 0 0 0 01 0 000000",
               busy, done, pix_valid, pix_last, bram_channel, bram_addr, pix_data);
    end
    checks++;
    if ({bram_we, bram_data_in} !== 9'h000) begin
      fails++; $display("FAIL reset_wr_tieoff: got we=%b din=%h, expected 0 00", bram_we, bram_data_in);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_stream;
    int n_valid = 0, n_done = 0, prev_c = 0, done_c = -1, exp_c;
    logic [23:0] e;
    push_frame(NP);
    pix_ready = 1'b1;
    start_scan();
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL stream_busy: got %b, expected 1", busy); end
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (pix_valid) begin
        exp_c = (n_valid == 0) ? 4 : prev_c + 5;
        checks++;
        if (c != exp_c) begin fails++; $display("FAIL stream_timing: pixel %0d at cycle %0d, expected %0d", n_valid, c, exp_c); end
        if (exp_q.size() == 0) e = 24'hxxxxxx; else e = exp_q.pop_front();
        checks++;
        if (pix_data !== e) begin fails++; $display("FAIL stream_data: got %h, expected %h", pix_data, e); end
        checks++;
        if (pix_last !== (n_valid == NP - 1)) begin
          fails++; $display("FAIL stream_last: pixel %0d got %b, expected %b", n_valid, pix_last, n_valid == NP - 1);
        end
        prev_c = c;
        n_valid++;
      end
      if (done) begin n_done++; done_c = c; end
    end
    checks++;
    if (n_valid != NP) begin fails++; $display("FAIL stream_count: got %0d pixels, expected %0d", n_valid, NP); end
    checks++;
    if (n_done != 1) begin fails++; $display("FAIL stream_done_count: got %0d, expected 1", n_done); end
    checks++;
    if (done_c != 20) begin fails++; $display("FAIL stream_done_time: got cycle %0d, expected 20", done_c); end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL stream_idle_busy: got %b, expected 0", busy); end
    exp_q.delete();
  endtask

  task automatic test_backpressure;
    int hold = 0, idx = 0, n_done = 0, h0 = -1, h1 = -1;
    logic [23:0] e;
    push_frame(NP);
    pix_ready = 1'b0;
    start_scan();
    for (int c = 0; c < 120; c++) begin
      if (c > 0) @(negedge clk);
      pix_ready = 1'b0;
      if (done) n_done++;
      if (pix_valid) begin
        if (idx == 1 && hold < 10) begin
          if (hold == 0) h0 = c;
          h1 = c;
          hold++;
          checks++;
          if (pix_data !== 24'h014181) begin fails++; $display("FAIL bp_hold_data: got %h, expected 014181", pix_data); end
          checks++;
          if (bram_addr !== 2'd1) begin fails++; $display("FAIL bp_hold_addr: got %0d, expected 1", bram_addr); end
        end else begin
          if (exp_q.size() == 0) e = 24'hxxxxxx; else e = exp_q.pop_front();
          checks++;
          if (pix_data !== e) begin fails++; $display("FAIL bp_data: got %h, expected %h", pix_data, e); end
          pix_ready = 1'b1;
          idx++;
        end
      end
      if (n_done != 0) break;
    end
    pix_ready = 1'b1;
    checks++;
    if (h1 - h0 != 9) begin fails++; $display("FAIL bp_valid_held: valid span %0d..%0d, expected 10 consecutive cycles", h0, h1); end
    checks++;
    if (idx != NP) begin fails++; $display("FAIL bp_count: got %0d pixels, expected %0d", idx, NP); end
    checks++;
    if (n_done != 1) begin fails++; $display("FAIL bp_done: got %0d, expected 1", n_done); end
    exp_q.delete();
  endtask

  task automatic test_ctrl_if;
    logic [1:0] ech;
    pix_ready = 1'b1;
    start_scan();
    for (int c = 0; c < 25; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if ({bram_we, bram_data_in} !== 9'h000) begin
        fails++; $display("FAIL if_write_tied: cycle %0d got we=%b din=%h, expected 0 00", c, bram_we, bram_data_in);
      end
      if (c < 20) begin
        ech = (c % 5 == 2) ? 2'b10 : (c % 5 == 3) ? 2'b11 : 2'b01;
        checks++;
        if (bram_channel !== ech) begin fails++; $display("FAIL if_channel: cycle %0d got %b, expected %b", c, bram_channel, ech); end
        checks++;
        if (bram_addr !== AW'(c / 5)) begin fails++; $display("FAIL if_addr: cycle %0d got %0d, expected %0d", c, bram_addr, c / 5); end
      end
    end
  endtask

  task automatic test_abort;
    int n_done = 0, n_valid = 0;
    logic [23:0] e;
    // Abort in CAP_G of pixel 2.
    push_frame(2);
    pix_ready = 1'b1;
    start_scan();
    for (int c = 0; c < 26; c++) begin
      if (c > 0) @(negedge clk);
      abort = 1'b0;
      if (done) n_done++;
      if (pix_valid) begin
        n_valid++;
        if (exp_q.size() == 0) e = 24'hxxxxxx; else e = exp_q.pop_front();
        checks++;
        if (pix_data !== e) begin fails++; $display("FAIL abort_pre_data: got %h, expected %h", pix_data, e); end
      end
      if (c == 12) begin
        checks++;
        if (bram_channel !== 2'b10) begin fails++; $display("FAIL abort_in_capg: got ch %b, expected 10", bram_channel); end
        abort = 1'b1;
      end
      if (c == 13) begin
        checks++;
        if ({busy, pix_valid, pix_last, bram_addr} !== 5'b0) begin
          fails++; $display("FAIL abort_state: got busy=%b vld=%b last=%b addr=%0d, expected 0 0 0 0", busy, pix_valid, pix_last, bram_addr);
        end
      end
    end
    checks++;
    if (n_done != 0 || n_valid != 2) begin fails++; $display("FAIL abort_no_done: got done=%0d pixels=%0d, expected 0 2", n_done, n_valid); end
    exp_q.delete();
    // Abort beats a same-cycle handshake on the last pixel.
    n_done = 0;
    start_scan();
    for (int c = 0; c < 26; c++) begin
      if (c > 0) @(negedge clk);
      abort = 1'b0;
      if (done) n_done++;
      if (c == 19) begin
        checks++;
        if ({pix_valid, pix_last} !== 2'b11) begin fails++; $display("FAIL abort_last_pres: got vld=%b last=%b, expected 1 1", pix_valid, pix_last); end
        abort = 1'b1;
      end
      if (c == 20) begin
        checks++;
        if ({busy, pix_valid} !== 2'b00) begin fails++; $display("FAIL abort_prio: got busy=%b vld=%b, expected 0 0", busy, pix_valid); end
      end
    end
    checks++;
    if (n_done != 0) begin fails++; $display("FAIL abort_prio_done: got %0d done pulses, expected 0", n_done); end
    // Start and abort together in IDLE: abort wins.
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL abort_start_clash: got busy=%b, expected 0", busy); end
    // Fresh start runs from address 0.
    push_frame(NP);
    n_done = 0; n_valid = 0;
    start_scan();
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (done) n_done++;
      if (pix_valid) begin
        if (n_valid == 0) begin
          checks++;
          if (c != 4 || bram_addr !== 2'd0) begin fails++; $display("FAIL restart_first: cycle %0d addr %0d, expected 4 0", c, bram_addr); end
        end
        n_valid++;
        if (exp_q.size() == 0) e = 24'hxxxxxx; else e = exp_q.pop_front();
        checks++;
        if (pix_data !== e) begin fails++; $display("FAIL restart_data: got %h, expected %h", pix_data, e); end
      end
    end
    checks++;
    if (n_done != 1 || n_valid != NP) begin fails++; $display("FAIL restart_done: got done=%0d pixels=%0d, expected 1 %0d", n_done, n_valid, NP); end
    exp_q.delete();
  endtask

  task automatic test_async_reset;
    pix_ready = 1'b1;
    start_scan();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 5) pix_ready = 1'b0;
    end
    checks++;
    if ({pix_valid, pix_data} !== {1'b1, 24'h014181}) begin
      fails++; $display("FAIL areset_pre: got vld=%b dat=%h, expected 1 014181", pix_valid, pix_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, pix_valid, pix_last, bram_channel, bram_addr, pix_data} !== {4'b0000, 2'b01, 2'b00, 24'h0}) begin
      fails++;
      $display("FAIL areset_immediate: got busy=%b vld=%b last=%b ch=%b addr=%0d dat=%h, expected 0 0 0 01 0 000000",
               busy, pix_valid, pix_last, bram_channel, bram_addr, pix_data);
    end
    @(negedge clk); rst_n = 1'b1;
    pix_ready = 1'b1;
  endtask

  task automatic test_start_ignored;
    int n_done = 0, n_valid = 0, done_c = -1;
    logic [23:0] e;
    push_frame(NP);
    pix_ready = 1'b1;
    start_scan();
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      start = (c == 7);
      if (c == 8) begin
        checks++;
        if ({busy, bram_addr} !== {1'b1, 2'd1}) begin fails++; $display("FAIL busy_start_addr: got busy=%b addr=%0d, expected 1 1", busy, bram_addr); end
      end
      if (done) begin n_done++; done_c = c; end
      if (pix_valid) begin
        n_valid++;
        if (exp_q.size() == 0) e = 24'hxxxxxx; else e = exp_q.pop_front();
        checks++;
        if (pix_data !== e) begin fails++; $display("FAIL busy_start_data: got %h, expected %h", pix_data, e); end
      end
    end
    start = 1'b0;
    checks++;
    if (n_done != 1 || n_valid != NP || done_c != 20) begin
      fails++; $display("FAIL busy_start_scan: got done=%0d pixels=%0d done_at=%0d, expected 1 %0d 20", n_done, n_valid, done_c, NP);
    end
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      r_mem[i] = 8'(i);
      g_mem[i] = 8'(i + 8'h40);
      b_mem[i] = 8'(i + 8'h80);
    end
    test_reset();
    test_stream();
    test_backpressure();
    test_ctrl_if();
    test_abort();
    test_async_reset();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
